product_accumulator: RTL and testbench

//  Downstream consumer of the synchronous 32x32 Booth multiplier's 64-bit signed product.

---
 rtl/product_accumulator.sv | 93 +++++++++
 tb/tb_product_accumulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums a stream of signed products into a wide accumulator, one result per vector (ended by prod_last).
// The finished sum sits behind a valid/ready handshake; no terms are taken while it waits.
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] product,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf,
  output logic              acc_valid,
  input  logic              acc_ready
);

  typedef enum logic {ST_ACCUM = 1'b0, ST_DONE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             first_q, first_d;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;

  assign prod_ext = ACC_W'($signed(product));
  assign sum      = acc_q + prod_ext;
  // Signed overflow: both operands agree in sign but the wrapped sum does not.
  assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    case (state_q)
      ST_ACCUM: begin
        if (prod_valid) begin
          if (first_q) begin
            acc_d = prod_ext;
            cnt_d = CNT_W'(1);
            ovf_d = 1'b0;
          end else begin
            acc_d = sum;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
          end
          first_d = prod_last;
          if (prod_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (acc_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
    end
  end

  assign prod_ready = (state_q == ST_ACCUM);
  assign acc_valid  = (state_q == ST_DONE);
  assign acc_out    = acc_q;
  assign acc_count  = cnt_q;
  assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives three accumulator builds (72-bit, 64-bit, 3-bit counter) with shared stimulus
// and compares each against a vector-level arithmetic reference.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] product = '0;
  logic        prod_valid = 1'b0;
  logic        prod_last = 1'b0;
  logic        acc_ready = 1'b0;

  logic        pr_a, av_a, ovf_a;
  logic [71:0] acc_a;
  logic [15:0] cnt_a;
  logic        pr_b, av_b, ovf_b;
  logic [63:0] acc_b;
  logic [15:0] cnt_b;
  logic        pr_c, av_c, ovf_c;
  logic [71:0] acc_c;
  logic [2:0]  cnt_c;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .product(product), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(pr_a), .acc_out(acc_a), .acc_count(cnt_a), .acc_ovf(ovf_a),
    .acc_valid(av_a), .acc_ready(acc_ready));

  product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .product(product), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(pr_b), .acc_out(acc_b), .acc_count(cnt_b), .acc_ovf(ovf_b),
    .acc_valid(av_b), .acc_ready(acc_ready));

  product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(3)) u_dut_c (
    .clk(clk), .rst(rst), .product(product), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(pr_c), .acc_out(acc_c), .acc_count(cnt_c), .acc_ovf(ovf_c),
    .acc_valid(av_c), .acc_ready(acc_ready));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: terms of the vector in flight, and the finished result per build.
  logic signed [63:0]  vec_q[$];
  bit                  pending = 1'b0;
  logic signed [127:0] exp_acc[3];
  int                  exp_cnt[3];
  bit                  exp_ovf[3];
  int                  widths[3] = '{72, 64, 72};
  int                  cmax[3]   = '{65535, 65535, 7};

  function automatic logic signed [127:0] wrapw(input logic signed [127:0] x, input int w);
    logic signed [127:0] t;
    t = x <<< (128 - w);
    return t >>> (128 - w);
  endfunction

  // Exact-integer sum of the terms; overflow whenever a partial sum falls outside w bits.
  function automatic void finish_vec();
    for (int k = 0; k < 3; k++) begin
      logic signed [127:0] acc, wide;
      bit ovf;
      acc = 0;
      ovf = 1'b0;
      foreach (vec_q[i]) begin
        wide = acc + 128'(vec_q[i]);
        if (i > 0 && wrapw(wide, widths[k]) != wide) ovf = 1'b1;
        acc = wrapw(wide, widths[k]);
      end
      exp_acc[k] = acc;
      exp_ovf[k] = ovf;
      exp_cnt[k] = (vec_q.size() > cmax[k]) ? cmax[k] : vec_q.size();
    end
    vec_q.delete();
  endfunction

  task automatic check_outputs();
    chk("prod_ready", 128'(pr_a), 128'(!pending));
    chk("acc_valid", 128'(av_a), 128'(pending));
    chk("acc_valid_64", 128'(av_b), 128'(pending));
    chk("acc_valid_c3", 128'(av_c), 128'(pending));
    if (pending) begin
      chk("acc_out", 128'(acc_a), 128'(exp_acc[0][71:0]));
      chk("acc_count", 128'(cnt_a), 128'(exp_cnt[0]));
      chk("acc_ovf", 128'(ovf_a), 128'(exp_ovf[0]));
      chk("acc_out_64", 128'(acc_b), 128'(exp_acc[1][63:0]));
      chk("acc_ovf_64", 128'(ovf_b), 128'(exp_ovf[1]));
      chk("acc_count_sat", 128'(cnt_c), 128'(exp_cnt[2]));
    end
  endtask

  task automatic step(input bit v, input bit l, input logic [63:0] p, input bit r);
    check_outputs();
    prod_valid = v;
    prod_last  = l;
    product    = p;
    acc_ready  = r;
    if (pending) begin
      if (r) pending = 1'b0;
    end else if (v) begin
      vec_q.push_back(p);
      if (l) begin
        finish_vec();
        pending = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_acc_out", 128'(acc_a), 128'(0));
    chk("rst_acc_count", 128'(cnt_a), 128'(0));
    chk("rst_acc_ovf", 128'(ovf_a), 128'(0));
    chk("rst_acc_valid", 128'(av_a), 128'(0));
    #6 rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: reset mid-vector discards the partial sum
    step(1, 0, 64'd10, 0);
    step(1, 0, 64'd20, 0);
    prod_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_valid", 128'(av_a), 128'(0));
    chk("t1_rst_count", 128'(cnt_a), 128'(0));
    vec_q.delete();
    pending = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t1_ready", 128'(pr_a), 128'(1));
    step(1, 1, 64'd5, 0);
    chk("t1_sum", 128'(acc_a), 128'(5));
    chk("t1_count", 128'(cnt_a), 128'(1));
    step(0, 0, 64'd0, 1);

    // T2: dot product 12 - 14 + 100
    step(1, 0, 64'd12, 1);
    step(1, 0, 64'(-14), 1);
    step(1, 1, 64'd100, 1);
    chk("t2_sum", 128'(acc_a), 128'(98));
    chk("t2_count", 128'(cnt_a), 128'(3));
    step(0, 0, 64'd0, 1);
    step(0, 0, 64'd0, 1);

    // T3: result held under backpressure, offered beats refused
    step(1, 0, 64'd1, 0);
    step(1, 1, 64'd2, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold", 128'(acc_a), 128'(3));
      step(1, 0, 64'd77, 0);
    end
    step(0, 0, 64'd0, 1);

    // T4: overflow at 64 bits, cleared by the next vector
    step(1, 0, 64'h4000_0000_0000_0000, 0);
    step(1, 1, 64'h4000_0000_0000_0000, 0);
    chk("t4_sum_64", 128'(acc_b), 128'(64'h8000_0000_0000_0000));
    chk("t4_ovf_64", 128'(ovf_b), 128'(1));
    step(0, 0, 64'd0, 1);
    step(1, 1, 64'(-1), 0);
    chk("t4_ovf_next", 128'(ovf_b), 128'(0));
    step(0, 0, 64'd0, 1);

    // T5: two most-negative products at 72 bits
    step(1, 0, 64'h8000_0000_0000_0000, 0);
    step(1, 1, 64'h8000_0000_0000_0000, 0);
    chk("t5_sum", 128'(acc_a), 128'(72'hFF_0000_0000_0000_0000));
    chk("t5_ovf", 128'(ovf_a), 128'(0));
    step(0, 0, 64'd0, 1);

    // T6: streaming with valid and ready held high, plus counter saturation
    step(1, 0, 64'd1, 1);
    step(1, 0, 64'd1, 1);
    step(1, 1, 64'd1, 1);
    chk("t6_first", 128'(acc_a), 128'(3));
    step(1, 1, 64'(-2), 1);
    step(1, 1, 64'(-2), 1);
    chk("t6_second", 128'(acc_a), 128'(72'hFF_FFFF_FFFF_FFFF_FFFE));
    step(0, 0, 64'd0, 1);
    for (int i = 0; i < 10; i++) step(1, (i == 9), 64'd2, 1);
    chk("sat_count_c3", 128'(cnt_c), 128'(7));
    step(0, 0, 64'd0, 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [63:0] p;
      int s;
      case ($urandom_range(0, 3))
        0: begin
          s = int'($urandom_range(0, 200)) - 100;
          p = 64'(longint'(s));
        end
        1: p = {$urandom(), $urandom()};
        2: p = {($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 30'($urandom()), $urandom()};
        default: p = ($urandom_range(0, 1) != 0) ? 64'h4000_0000_0000_0000 : 64'hC000_0000_0000_0000;
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, p, $urandom_range(0, 2) != 0);
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
